counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 138 +++++++++++++
 tb/tb_counter_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Two-requester command arbiter driving an external up/down counter (IDLE -> ISSUE -> SETTLE).
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise A has fixed priority over B.
module counter_arbiter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [1:0]       a_op,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    output logic             a_done,
    input  logic             b_valid,
    input  logic [1:0]       b_op,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             b_done,
    output logic [1:0]       status,
    output logic             cnt_load,
    output logic             cnt_up,
    output logic             cnt_down,
    output logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_high,
    input  logic             cnt_low
);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             owner_q, owner_d;   // 0 = A, 1 = B
    logic [1:0]       status_q, status_d;
    logic             a_done_q, a_done_d;
    logic             b_done_q, b_done_d;
    logic             idle, issue, gnt_a, gnt_b;
    logic [1:0]       issue_status;

    // Ready is gated by rst_n so nothing is granted while reset is held.
    assign idle  = (state_q == IDLE) && rst_n;
    assign issue = (state_q == ISSUE);

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;   // 0 = A has priority, 1 = B has priority
    assign gnt_a = idle && a_valid && (!b_valid || !ptr_q);
`else
    assign gnt_a = idle && a_valid;
`endif
    assign gnt_b = idle && b_valid && !gnt_a;

    assign a_ready = gnt_a;
    assign b_ready = gnt_b;

    // Counter controls decode only registered command state plus the counter's own flags.
    assign cnt_load = issue && (op_q == OP_LOAD);
    assign cnt_up   = issue && (op_q == OP_UP)   && !cnt_high;
    assign cnt_down = issue && (op_q == OP_DOWN) && !cnt_low;
    assign cnt_in   = cnt_load ? data_q : '0;

    assign a_done = a_done_q;
    assign b_done = b_done_q;
    assign status = status_q;

    always_comb begin
        issue_status = 2'b00;
        case (op_q)
            OP_NOP:  issue_status = 2'b11;
            OP_UP:   issue_status = cnt_high ? 2'b01 : 2'b00;
            OP_DOWN: issue_status = cnt_low  ? 2'b10 : 2'b00;
            default: issue_status = 2'b00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        data_d   = data_q;
        owner_d  = owner_q;
        status_d = 2'b00;
        a_done_d = 1'b0;
        b_done_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_a || gnt_b) begin
                    state_d = ISSUE;
                    op_d    = gnt_a ? a_op : b_op;
                    data_d  = gnt_a ? a_data : b_data;
                    owner_d = gnt_b;
`ifdef ARB_ROUND_ROBIN_EN
                    ptr_d   = gnt_a;
`endif
                end
            end
            ISSUE: begin
                state_d  = SETTLE;
                status_d = issue_status;
                a_done_d = !owner_q;
                b_done_d = owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            data_q   <= '0;
            owner_q  <= 1'b0;
            status_q <= 2'b00;
            a_done_q <= 1'b0;
            b_done_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            owner_q  <= owner_d;
            status_q <= status_d;
            a_done_q <= a_done_d;
            b_done_q <= b_done_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: vector table, hand-written corner sequences, and random stimulus
// checked against a cycle-count reference model.
module tb_counter_arbiter;

    localparam int W = 5;

    logic         clk, rst_n;
    logic         a_valid, b_valid, a_ready, b_ready, a_done, b_done;
    logic [1:0]   a_op, b_op, status;
    logic [W-1:0] a_data, b_data, cnt_in;
    logic         cnt_load, cnt_up, cnt_down, cnt_high, cnt_low;

    int n_chk = 0;
    int n_fail = 0;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    counter_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_op(a_op), .a_data(a_data), .a_ready(a_ready), .a_done(a_done),
        .b_valid(b_valid), .b_op(b_op), .b_data(b_data), .b_ready(b_ready), .b_done(b_done),
        .status(status), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_down(cnt_down),
        .cnt_in(cnt_in), .cnt_high(cnt_high), .cnt_low(cnt_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {a_ready, b_ready, load, up, down, a_done, b_done, status[1:0], cnt_in[4:0]}
    typedef logic [13:0] obs_t;

    typedef struct {
        logic       av;
        logic [1:0] aop;
        logic [4:0] ad;
        logic       bv;
        logic [1:0] bop;
        logic [4:0] bd;
        logic       hi;
        logic       lo;
        obs_t       exp;
    } vec_t;

    function automatic obs_t e(input logic ar, input logic br, input logic ld, input logic up,
                               input logic dn, input logic ad, input logic bd,
                               input logic [1:0] st, input logic [4:0] ci);
        return {ar, br, ld, up, dn, ad, bd, st, ci};
    endfunction

    function automatic obs_t obs();
        return {a_ready, b_ready, cnt_load, cnt_up, cnt_down, a_done, b_done, status, cnt_in};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic av, input logic [1:0] aop, input logic [4:0] ad,
                         input logic bv, input logic [1:0] bop, input logic [4:0] bd,
                         input logic hi, input logic lo);
        @(negedge clk);
        a_valid = av; a_op = aop; a_data = ad;
        b_valid = bv; b_op = bop; b_data = bd;
        cnt_high = hi; cnt_low = lo;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_valid = 1'b1; a_op = 2'b11; a_data = 5'd9;
        b_valid = 1'b1; b_op = 2'b01; b_data = 5'd3;
        cnt_high = 1'b0; cnt_low = 1'b0;
        #1;
        chk("reset_outputs", 32'(obs()), 32'(obs_t'(0)));
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    vec_t tbl[21];

    // Reference model: command accepted at cycle t produces control at t+1 and done at t+2.
    bit         m_busy, m_prefer_b, m_owner_b;
    int         m_acc, cyc;
    logic [1:0] m_op, m_status;
    logic [4:0] m_data;

    function automatic obs_t model_step();
        obs_t x = '0;
        if (!m_busy) begin
            int win = 0;   // 0 none, 1 A, 2 B
            if (a_valid && b_valid) win = (RR && m_prefer_b) ? 2 : 1;
            else if (a_valid) win = 1;
            else if (b_valid) win = 2;
            if (win != 0) begin
                m_busy = 1; m_acc = cyc; m_owner_b = (win == 2);
                m_op = m_owner_b ? b_op : a_op;
                m_data = m_owner_b ? b_data : a_data;
                m_prefer_b = (win == 1);
                x[13] = (win == 1);
                x[12] = (win == 2);
            end
        end else if (cyc == m_acc + 1) begin
            m_status = 2'b00;
            case (m_op)
                2'b00: m_status = 2'b11;
                2'b01: if (cnt_high) m_status = 2'b01; else x[10] = 1'b1;
                2'b10: if (cnt_low)  m_status = 2'b10; else x[9]  = 1'b1;
                default: begin x[11] = 1'b1; x[4:0] = m_data; end
            endcase
        end else if (cyc == m_acc + 2) begin
            x[8] = !m_owner_b;
            x[7] = m_owner_b;
            x[6:5] = m_status;
            m_busy = 0;
        end
        return x;
    endfunction

    initial begin
        rst_n = 1'b0;
        a_valid = 0; a_op = 0; a_data = 0; b_valid = 0; b_op = 0; b_data = 0;
        cnt_high = 0; cnt_low = 0;

        tbl[0]  = '{1'b1, 2'b11, 5'd20, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(1,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[1]  = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(0,0,1,0,0,0,0,2'b00,5'd20)};
        tbl[2]  = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(0,0,0,0,0,1,0,2'b00,5'd0)};
        tbl[3]  = '{1'b0, 2'b00, 5'd0,  1'b1, 2'b01, 5'd0, 1'b1, 1'b0, e(0,1,0,0,0,0,0,2'b00,5'd0)};
        tbl[4]  = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b0, e(0,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[5]  = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b0, e(0,0,0,0,0,0,1,2'b01,5'd0)};
        tbl[6]  = '{1'b1, 2'b10, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b1, e(1,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[7]  = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b1, e(0,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[8]  = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b1, e(0,0,0,0,0,1,0,2'b10,5'd0)};
        tbl[9]  = '{1'b1, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(1,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[10] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(0,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[11] = '{1'b0, 2'b00, 5'd0,  1'b1, 2'b01, 5'd0, 1'b0, 1'b0, e(0,0,0,0,0,1,0,2'b11,5'd0)};
        tbl[12] = '{1'b0, 2'b00, 5'd0,  1'b1, 2'b01, 5'd0, 1'b0, 1'b0, e(0,1,0,0,0,0,0,2'b00,5'd0)};
        tbl[13] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(0,0,0,1,0,0,0,2'b00,5'd0)};
        tbl[14] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b0, 1'b0, e(0,0,0,0,0,0,1,2'b00,5'd0)};
        tbl[15] = '{1'b1, 2'b01, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b1, e(1,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[16] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b1, e(0,0,0,0,0,0,0,2'b00,5'd0)};
        tbl[17] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b1, e(0,0,0,0,0,1,0,2'b01,5'd0)};
        tbl[18] = '{1'b0, 2'b00, 5'd0,  1'b1, 2'b11, 5'd31, 1'b1, 1'b1, e(0,1,0,0,0,0,0,2'b00,5'd0)};
        tbl[19] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b1, e(0,0,1,0,0,0,0,2'b00,5'd31)};
        tbl[20] = '{1'b0, 2'b00, 5'd0,  1'b0, 2'b00, 5'd0, 1'b1, 1'b1, e(0,0,0,0,0,0,1,2'b00,5'd0)};

        do_reset();
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].av, tbl[i].aop, tbl[i].ad, tbl[i].bv, tbl[i].bop, tbl[i].bd,
                  tbl[i].hi, tbl[i].lo);
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
        end

        // Both requesters held valid: alternate under round-robin, A only under fixed priority.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            logic [1:0] want;
            drive(1'b1, 2'b01, 5'd0, 1'b1, 2'b01, 5'd0, 1'b0, 1'b0);
            want = 2'b00;
            if (k % 3 == 0) want = (RR && ((k / 3) % 2 == 1)) ? 2'b01 : 2'b10;
            chk($sformatf("arb_k%0d", k), 32'({a_ready, b_ready}), 32'(want));
        end

        // Reset dropped mid-ISSUE of a load: outputs clear at once and no done follows.
        do_reset();
        drive(1'b1, 2'b11, 5'd7, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        chk("rst_issue_accept", 32'(obs()), 32'(e(1,0,0,0,0,0,0,2'b00,5'd0)));
        drive(1'b0, 2'b00, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        chk("rst_issue_load", 32'(obs()), 32'(e(0,0,1,0,0,0,0,2'b00,5'd7)));
        #2 rst_n = 1'b0;
        #1 chk("rst_async_clear", 32'(obs()), 32'(obs_t'(0)));
        drive(1'b0, 2'b00, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        chk("rst_no_done", 32'(obs()), 32'(obs_t'(0)));
        @(negedge clk);
        rst_n = 1'b1;
        a_valid = 1'b1; a_op = 2'b01; b_valid = 1'b1; b_op = 2'b01;
        #1 chk("rst_regrant_a", 32'(obs()), 32'(e(1,0,0,0,0,0,0,2'b00,5'd0)));
        drive(1'b0, 2'b00, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        chk("rst_regrant_up", 32'(obs()), 32'(e(0,0,0,1,0,0,0,2'b00,5'd0)));
        drive(1'b0, 2'b00, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 1'b0);
        chk("rst_regrant_done", 32'(obs()), 32'(e(0,0,0,0,0,1,0,2'b00,5'd0)));

        // Random traffic against the reference model.
        do_reset();
        m_busy = 0; m_prefer_b = 0; m_acc = 0;
        for (cyc = 0; cyc < 400; cyc++) begin
            obs_t want;
            drive(1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
                  1'($urandom_range(0, 1)), 2'($urandom), 5'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            want = model_step();
            chk($sformatf("rand_c%0d", cyc), 32'(obs()), 32'(want));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
